// File: rtl/alarm_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alarm_ctrl_pkg : state codes, counter widths, adjust-field step helpers     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package alarm_ctrl_pkg;

   typedef logic [2:0] state_t;

   localparam state_t S_CLOCK   = 3'd0;
   localparam state_t S_ADJ_TH  = 3'd1;
   localparam state_t S_ADJ_TM  = 3'd2;
   localparam state_t S_ADJ_AH  = 3'd3;
   localparam state_t S_ADJ_AM  = 3'd4;
   localparam state_t S_RINGING = 3'd5;
   localparam state_t S_SNOOZE  = 3'd6;

   localparam int RING_CNT_W   = 6;
   localparam int SNOOZE_CNT_W = 3;

   function automatic state_t adj_next(input state_t s);
      case (s)
         S_ADJ_TH: return S_ADJ_TM;
         S_ADJ_TM: return S_ADJ_AH;
         S_ADJ_AH: return S_ADJ_AM;
         default:  return S_ADJ_TH;
      endcase
   endfunction

   function automatic state_t adj_prev(input state_t s);
      case (s)
         S_ADJ_TH: return S_ADJ_AM;
         S_ADJ_AM: return S_ADJ_AH;
         S_ADJ_AH: return S_ADJ_TM;
         default:  return S_ADJ_TH;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/alarm_mode_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alarm_mode_controller_if : button/flag inputs and datapath control outputs  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface alarm_mode_controller_if;
   logic       sec_tick;
   logic       btn_mode;
   logic       btn_left;
   logic       btn_right;
   logic       btn_snooze;
   logic       btn_stop;
   logic       alarm_sw;
   logic       Z;
   logic       z_s;
   logic       adjust;
   logic       ENTH;
   logic       ENTM;
   logic       ENAH;
   logic       ENAM;
   logic       ENS;
   logic       snooze_rst;
   logic       snoozeEN;
   logic       buzzer;
   logic       ringing;
   logic [2:0] mode;

   modport master (
      output sec_tick, btn_mode, btn_left, btn_right, btn_snooze, btn_stop, alarm_sw, Z, z_s,
      input  adjust, ENTH, ENTM, ENAH, ENAM, ENS, snooze_rst, snoozeEN, buzzer, ringing, mode
   );

   modport slave (
      input  sec_tick, btn_mode, btn_left, btn_right, btn_snooze, btn_stop, alarm_sw, Z, z_s,
      output adjust, ENTH, ENTM, ENAH, ENAM, ENS, snooze_rst, snoozeEN, buzzer, ringing, mode
   );
endinterface
`default_nettype wire

// File: rtl/btn_edge_detect.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | btn_edge_detect : one-cycle rising-edge pulses for a vector of levels       |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module btn_edge_detect #(
   parameter int W = 5
) (
   input  wire logic         funct_clk,
   input  wire logic         rst,
   input  wire logic [W-1:0] i_level,
   output logic      [W-1:0] o_rise
);
   logic [W-1:0] r_prev;

   always_ff @(posedge funct_clk or negedge rst) begin
      if (!rst) r_prev <= '0;
      else      r_prev <= i_level;
   end

   assign o_rise = i_level & ~r_prev;
endmodule
`default_nettype wire

// File: rtl/alarm_mode_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alarm_mode_controller : mode/adjust sequencing, alarm ring, snooze, timeout |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module alarm_mode_controller
   import alarm_ctrl_pkg::*;
#(
   parameter int RING_TIMEOUT = 60,
   parameter int MAX_SNOOZE   = 3
) (
   input wire logic               funct_clk,
   input wire logic               rst,
   alarm_mode_controller_if.slave bus
);
   localparam logic [RING_CNT_W-1:0]   c_ring_last  = RING_CNT_W'(RING_TIMEOUT - 1);
   localparam logic [SNOOZE_CNT_W-1:0] c_snooze_max = SNOOZE_CNT_W'(MAX_SNOOZE);

   state_t                  r_state;
   logic [RING_CNT_W-1:0]   r_ring_cnt;
   logic [SNOOZE_CNT_W-1:0] r_snooze_cnt;
   logic                    r_z_q;
   logic                    r_buzzer;
   logic                    r_snooze_rst;
   logic [4:0]              w_rise;
   logic                    w_z_rise;

   btn_edge_detect #(.W(5)) u_btn_edge (
      .funct_clk (funct_clk),
      .rst       (rst),
      .i_level   ({bus.btn_stop, bus.btn_snooze, bus.btn_right, bus.btn_left, bus.btn_mode}),
      .o_rise    (w_rise)
   );

   assign w_z_rise = bus.Z & ~r_z_q;

   // r_z_q resets high so a match already present when reset releases is not an alarm event
   always_ff @(posedge funct_clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_CLOCK;
         r_ring_cnt   <= '0;
         r_snooze_cnt <= '0;
         r_z_q        <= 1'b1;
         r_buzzer     <= 1'b0;
         r_snooze_rst <= 1'b0;
      end else begin
         r_z_q        <= bus.Z;
         r_snooze_rst <= 1'b0;
         case (r_state)
            S_CLOCK: begin
               if (w_rise[0]) begin
                  r_state <= S_ADJ_TH;
               end else if (w_z_rise && bus.alarm_sw) begin
                  r_state      <= S_RINGING;
                  r_ring_cnt   <= '0;
                  r_snooze_cnt <= '0;
                  r_buzzer     <= 1'b0;
               end
            end
            S_ADJ_TH, S_ADJ_TM, S_ADJ_AH, S_ADJ_AM: begin
               if (w_rise[0])                    r_state <= S_CLOCK;
               else if (w_rise[2] && !w_rise[1]) r_state <= adj_next(r_state);
               else if (w_rise[1] && !w_rise[2]) r_state <= adj_prev(r_state);
            end
            S_RINGING: begin
               if (w_rise[4] || !bus.alarm_sw) begin
                  r_state      <= S_CLOCK;
                  r_ring_cnt   <= '0;
                  r_snooze_cnt <= '0;
                  r_buzzer     <= 1'b0;
               end else if (w_rise[3] && (r_snooze_cnt < c_snooze_max)) begin
                  r_state      <= S_SNOOZE;
                  r_snooze_cnt <= r_snooze_cnt + SNOOZE_CNT_W'(1);
                  r_snooze_rst <= 1'b1;
                  r_buzzer     <= 1'b0;
               end else if (bus.sec_tick) begin
                  if (r_ring_cnt == c_ring_last) begin
                     r_state      <= S_CLOCK;
                     r_ring_cnt   <= '0;
                     r_snooze_cnt <= '0;
                     r_buzzer     <= 1'b0;
                  end else begin
                     if (r_ring_cnt != '1) r_ring_cnt <= r_ring_cnt + RING_CNT_W'(1);
                     r_buzzer <= ~r_buzzer;
                  end
               end
            end
            S_SNOOZE: begin
               if (w_rise[4] || !bus.alarm_sw) begin
                  r_state      <= S_CLOCK;
                  r_ring_cnt   <= '0;
                  r_snooze_cnt <= '0;
                  r_snooze_rst <= 1'b1;
                  r_buzzer     <= 1'b0;
               end else if (bus.z_s) begin
                  r_state    <= S_RINGING;
                  r_ring_cnt <= '0;
               end
            end
            default: r_state <= S_CLOCK;
         endcase
      end
   end

   assign bus.adjust     = (r_state == S_ADJ_TH) || (r_state == S_ADJ_TM) ||
                           (r_state == S_ADJ_AH) || (r_state == S_ADJ_AM);
   assign bus.ENTH       = (r_state == S_ADJ_TH);
   assign bus.ENTM       = (r_state == S_ADJ_TM);
   assign bus.ENAH       = (r_state == S_ADJ_AH);
   assign bus.ENAM       = (r_state == S_ADJ_AM);
   assign bus.ENS        = (r_state == S_ADJ_TH) || (r_state == S_ADJ_TM);
   assign bus.snoozeEN   = (r_state == S_SNOOZE);
   assign bus.ringing    = (r_state == S_RINGING) || (r_state == S_SNOOZE);
   assign bus.buzzer     = r_buzzer;
   assign bus.snooze_rst = r_snooze_rst;
   assign bus.mode       = r_state;
endmodule
`default_nettype wire

// File: tb/tb_alarm_mode_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alarm_mode_controller : directed scenarios plus random run vs. model     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_alarm_mode_controller;
   import alarm_ctrl_pkg::*;

   localparam int RT = 60;
   localparam int MS = 3;
   localparam logic [4:0] B_MODE   = 5'b00001;
   localparam logic [4:0] B_LEFT   = 5'b00010;
   localparam logic [4:0] B_RIGHT  = 5'b00100;
   localparam logic [4:0] B_SNOOZE = 5'b01000;
   localparam logic [4:0] B_STOP   = 5'b10000;
   localparam logic [2:0] ADJ_CODES [4] = '{S_ADJ_TH, S_ADJ_TM, S_ADJ_AH, S_ADJ_AM};
   localparam logic [4:0] NAV_BTN   [7] = '{B_MODE, B_RIGHT, B_RIGHT, B_RIGHT, B_RIGHT, B_LEFT, B_MODE};
   localparam logic [2:0] NAV_MODE  [7] = '{S_ADJ_TH, S_ADJ_TM, S_ADJ_AH, S_ADJ_AM, S_ADJ_TH, S_ADJ_AM, S_CLOCK};

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   int         n_checks = 0;
   int         n_pass   = 0;
   logic       t_tick = 1'b0, t_sw = 1'b0, t_z = 1'b0, t_zs = 1'b0;
   logic [4:0] t_btn  = '0;

   // reference model: phase + adjust-field index, ring seconds elapsed, snoozes used
   typedef enum {M_CLOCK, M_ADJ, M_RING, M_SNZ} mphase_t;
   mphase_t    m_ph;
   int         m_idx, m_ring, m_snz;
   logic       m_buzz, m_srst, m_zq;
   logic [4:0] m_prev;

   alarm_mode_controller_if bus_if();

   alarm_mode_controller #(.RING_TIMEOUT(RT), .MAX_SNOOZE(MS)) dut (
      .funct_clk (clk),
      .rst       (rst_n),
      .bus       (bus_if)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached, got running required finished");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   function automatic logic [12:0] dut_pack();
      return {bus_if.mode, bus_if.adjust, bus_if.ENTH, bus_if.ENTM, bus_if.ENAH, bus_if.ENAM,
              bus_if.ENS, bus_if.snooze_rst, bus_if.snoozeEN, bus_if.buzzer, bus_if.ringing};
   endfunction

   function automatic logic [12:0] model_pack();
      logic [2:0] code;
      logic       adj;
      adj = (m_ph == M_ADJ);
      case (m_ph)
         M_CLOCK: code = S_CLOCK;
         M_ADJ:   code = ADJ_CODES[m_idx];
         M_RING:  code = S_RINGING;
         default: code = S_SNOOZE;
      endcase
      return {code, adj, adj && m_idx == 0, adj && m_idx == 1, adj && m_idx == 2, adj && m_idx == 3,
              adj && m_idx < 2, m_srst, m_ph == M_SNZ, m_buzz, (m_ph == M_RING) || (m_ph == M_SNZ)};
   endfunction

   task automatic model_reset();
      m_ph = M_CLOCK; m_idx = 0; m_ring = 0; m_snz = 0;
      m_buzz = 1'b0; m_srst = 1'b0; m_zq = 1'b1; m_prev = '0;
   endtask

   task automatic model_to_clock();
      m_ph = M_CLOCK; m_ring = 0; m_snz = 0; m_buzz = 1'b0;
   endtask

   task automatic model_step();
      logic [4:0] e;
      logic       zr;
      e = t_btn & ~m_prev;  m_prev = t_btn;
      zr = t_z && !m_zq;    m_zq = t_z;
      m_srst = 1'b0;
      case (m_ph)
         M_CLOCK:
            if (e[0]) begin m_ph = M_ADJ; m_idx = 0; end
            else if (zr && t_sw) begin m_ph = M_RING; m_ring = 0; m_snz = 0; m_buzz = 1'b0; end
         M_ADJ:
            if (e[0]) m_ph = M_CLOCK;
            else if (e[2] && !e[1]) m_idx = (m_idx + 1) % 4;
            else if (e[1] && !e[2]) m_idx = (m_idx + 3) % 4;
         M_RING:
            if (e[4] || !t_sw) model_to_clock();
            else if (e[3] && m_snz < MS) begin
               m_ph = M_SNZ; m_snz++; m_srst = 1'b1; m_buzz = 1'b0;
            end else if (t_tick) begin
               m_ring++;
               if (m_ring >= RT) model_to_clock();
               else m_buzz = !m_buzz;
            end
         default:
            if (e[4] || !t_sw) begin model_to_clock(); m_srst = 1'b1; end
            else if (t_zs) begin m_ph = M_RING; m_ring = 0; end
      endcase
   endtask

   // called at a falling edge: drive, let one rising edge pass, compare at the next falling edge
   task automatic step();
      bus_if.sec_tick   = t_tick;
      bus_if.btn_mode   = t_btn[0];
      bus_if.btn_left   = t_btn[1];
      bus_if.btn_right  = t_btn[2];
      bus_if.btn_snooze = t_btn[3];
      bus_if.btn_stop   = t_btn[4];
      bus_if.alarm_sw   = t_sw;
      bus_if.Z          = t_z;
      bus_if.z_s        = t_zs;
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("outputs", 32'(dut_pack()), 32'(model_pack()));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      #1;
      check("reset_outputs", 32'(dut_pack()), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic press(input logic [4:0] b);
      t_btn = b;  step();
      t_btn = '0; step();
   endtask

   task automatic ring_up();
      t_z = 1'b0; step();
      t_z = 1'b1; step();
      check("ring_start", 32'(bus_if.mode), 32'(S_RINGING));
   endtask

   initial begin
      int toggles;
      logic prev_buz;
      model_reset();
      t_sw = 1'b0;
      bus_if.sec_tick = 1'b0; bus_if.btn_mode = 1'b0; bus_if.btn_left = 1'b0; bus_if.btn_right = 1'b0;
      bus_if.btn_snooze = 1'b0; bus_if.btn_stop = 1'b0; bus_if.alarm_sw = 1'b0; bus_if.Z = 1'b0; bus_if.z_s = 1'b0;
      @(negedge clk);
      do_reset();

      for (int i = 0; i < 7; i++) begin
         t_btn = NAV_BTN[i]; step();
         check($sformatf("nav_mode_%0d", i), 32'(bus_if.mode), 32'(NAV_MODE[i]));
         t_btn = '0; step();
      end

      t_sw = 1'b1;
      ring_up();
      toggles = 0;
      prev_buz = bus_if.buzzer;
      for (int i = 0; i < RT; i++) begin
         t_tick = 1'b1; step();
         if (bus_if.buzzer !== prev_buz) toggles++;
         prev_buz = bus_if.buzzer;
         t_tick = 1'b0; step();
      end
      check("timeout_mode", 32'(bus_if.mode), 32'(S_CLOCK));
      check("timeout_toggles", 32'(toggles), 32'(RT));

      ring_up();
      for (int k = 0; k < MS; k++) begin
         t_btn = B_SNOOZE; step();
         check($sformatf("snz_rst_%0d", k), 32'(bus_if.snooze_rst), 32'd1);
         check($sformatf("snz_mode_%0d", k), 32'(bus_if.mode), 32'(S_SNOOZE));
         t_btn = '0; step();
         check($sformatf("snz_rst_off_%0d", k), 32'(bus_if.snooze_rst), 32'd0);
         t_zs = 1'b1; step(); t_zs = 1'b0;
         check($sformatf("snz_back_%0d", k), 32'(bus_if.mode), 32'(S_RINGING));
      end
      t_btn = B_SNOOZE; step();
      check("snz_extra_ignored", 32'(bus_if.mode), 32'(S_RINGING));
      t_btn = '0; step();
      press(B_STOP);
      check("stop_mode", 32'(bus_if.mode), 32'(S_CLOCK));

      ring_up();
      t_btn = B_STOP | B_SNOOZE; step();
      check("stop_snooze_mode", 32'(bus_if.mode), 32'(S_CLOCK));
      t_btn = '0; step();
      ring_up();
      press(B_SNOOZE);
      check("snz_after_stop", 32'(bus_if.mode), 32'(S_SNOOZE));
      t_sw = 1'b0; step();
      check("sw_off_mode", 32'(bus_if.mode), 32'(S_CLOCK));
      check("sw_off_snz_rst", 32'(bus_if.snooze_rst), 32'd1);
      t_sw = 1'b1; step();

      t_z = 1'b0; step();
      press(B_MODE);
      press(B_LEFT);
      t_z = 1'b1; step();
      check("adj_z_mode", 32'(bus_if.mode), 32'(S_ADJ_AM));
      check("adj_z_ring", 32'(bus_if.ringing), 32'd0);
      press(B_MODE);
      step();
      check("adj_exit_no_ring", 32'(bus_if.ringing), 32'd0);
      t_z = 1'b0; step();
      t_z = 1'b1; t_btn = B_MODE; step();
      check("mode_z_same_mode", 32'(bus_if.mode), 32'(S_ADJ_TH));
      check("mode_z_same_ring", 32'(bus_if.ringing), 32'd0);
      t_btn = '0; step();
      press(B_MODE);
      check("mode_z_lost", 32'(bus_if.ringing), 32'd0);

      ring_up();
      t_tick = 1'b1; step(); t_tick = 1'b0;
      do_reset();
      for (int i = 0; i < 5; i++) step();
      check("post_reset_no_ring", 32'(bus_if.ringing), 32'd0);

      for (int i = 0; i < 4000; i++) begin
         t_tick = ($urandom_range(0, 3) == 0);
         for (int b = 0; b < 5; b++) t_btn[b] = ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 49) == 0) t_sw = !t_sw;
         if (!t_sw && $urandom_range(0, 9) == 0) t_sw = 1'b1;
         if ($urandom_range(0, 14) == 0) t_z = !t_z;
         t_zs = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 999) == 0) do_reset();
         else step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
